// File: rtl/timer_sequencer.sv
// Countdown-timer control sequencer: debounces the push buttons and runs the
// IDLE/ARMED/RUNNING/PAUSED/ALARM control FSM that drives load, run, buzzer and LEDs.
module timer_sequencer #(
  parameter int unsigned DEB_CYCLES    = 20,
  parameter int unsigned BEEP_PERIOD   = 500,
  parameter int unsigned ALARM_TOGGLES = 60
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] psw_i,
  input  logic [3:0] rsw_i,
  input  logic       cnt_zero_i,
  output logic       load_o,
  output logic       run_o,
  output logic       bz_o,
  output logic [7:0] led_o,
  output logic [2:0] state_o
);

  localparam int unsigned NBTN   = 3;
  localparam int unsigned DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int unsigned BEEP_W = $clog2(BEEP_PERIOD + 1);
  localparam int unsigned TOG_W  = $clog2(ALARM_TOGGLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_RUNNING = 3'd2,
    S_PAUSED  = 3'd3,
    S_ALARM   = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // Button front end: synchronizer, debounce, press-edge detect
  // ---------------------------------------------------------------------------
  logic [NBTN-1:0]  sync1_q, sync2_q;
  logic [NBTN-1:0]  acc_q, acc_d;
  logic [NBTN-1:0]  press_q;
  logic [DEB_W-1:0] deb_cnt_q [NBTN];
  logic [DEB_W-1:0] deb_cnt_d [NBTN];
  logic             psw_unused;

  assign psw_unused = psw_i[3];

  // Count consecutive samples that disagree with the accepted level.
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < int'(NBTN); i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != acc_q[i]) begin
        if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
          acc_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      acc_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < int'(NBTN); i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= psw_i[NBTN-1:0];
      sync2_q <= sync1_q;
      acc_q   <= acc_d;
      press_q <= acc_d & ~acc_q;
      for (int i = 0; i < int'(NBTN); i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  // Press priority: stop > reload > start.
  logic stop_c, reload_c, start_c;
  assign stop_c   = press_q[1];
  assign reload_c = press_q[2] & ~press_q[1];
  assign start_c  = press_q[0] & ~press_q[1] & ~press_q[2];

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic              load_q, load_d;
  logic              bz_q, bz_d;
  logic [BEEP_W-1:0] beep_q, beep_d;
  logic [TOG_W-1:0]  tog_q, tog_d;
  logic [7:0]        led_q, led_d;
  logic              rsw_zero_c;
  logic              rearm_c;

  assign rsw_zero_c = (rsw_i == 4'd0);

  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    bz_d    = bz_q;
    beep_d  = beep_q;
    tog_d   = tog_q;
    rearm_c = 1'b0;
    led_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (!rsw_zero_c) rearm_c = 1'b1;
      end
      S_ARMED: begin
        if (reload_c)     rearm_c = 1'b1;
        else if (start_c) state_d = S_RUNNING;
      end
      S_RUNNING: begin
        if (cnt_zero_i) begin
          state_d = S_ALARM;
          bz_d    = 1'b1;
          beep_d  = '0;
          tog_d   = '0;
        end else if (stop_c) begin
          rearm_c = 1'b1;
        end else if (start_c) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (stop_c)       rearm_c = 1'b1;
        else if (start_c) state_d = S_RUNNING;
      end
      S_ALARM: begin
        if (stop_c) begin
          rearm_c = 1'b1;
        end else if (beep_q == BEEP_W'(BEEP_PERIOD - 1)) begin
          beep_d = '0;
          // The final toggle ends the alarm instead of re-raising the buzzer.
          if (tog_q == TOG_W'(ALARM_TOGGLES - 1)) begin
            rearm_c = 1'b1;
          end else begin
            bz_d  = ~bz_q;
            tog_d = tog_q + TOG_W'(1);
          end
        end else begin
          beep_d = beep_q + BEEP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every return to ARMED reloads the counters, unless there is nothing to load.
    if (rearm_c) begin
      bz_d = 1'b0;
      if (rsw_zero_c) begin
        state_d = S_IDLE;
      end else begin
        state_d = S_ARMED;
        load_d  = 1'b1;
      end
    end

    led_d[7]   = rsw_zero_c;
    led_d[4:0] = 5'b00001 << state_d;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      load_q  <= 1'b0;
      bz_q    <= 1'b0;
      beep_q  <= '0;
      tog_q   <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      bz_q    <= bz_d;
      beep_q  <= beep_d;
      tog_q   <= tog_d;
      led_q   <= led_d;
    end
  end

  // Run is gated combinationally so the counters stop on the zero cycle itself.
  assign run_o   = (state_q == S_RUNNING) & ~cnt_zero_i;
  assign load_o  = load_q;
  assign bz_o    = bz_q;
  assign led_o   = led_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: directed vector table, hand-written corner sequences,
// and random stimulus compared each cycle against a behavioural model.
`timescale 1ns/1ps
module tb_timer_sequencer;

  localparam int DEB = 4;
  localparam int PER = 8;
  localparam int TOG = 6;

  logic       clk = 1'b0;
  logic       rst_r, cz_r;
  logic [3:0] psw_r, rsw_r;
  logic       load_w, run_w, bz_w;
  logic [7:0] led_w;
  logic [2:0] state_w;

  timer_sequencer #(
    .DEB_CYCLES   (DEB),
    .BEEP_PERIOD  (PER),
    .ALARM_TOGGLES(TOG)
  ) dut (
    .clk_i      (clk),
    .reset_i    (rst_r),
    .psw_i      (psw_r),
    .rsw_i      (rsw_r),
    .cnt_zero_i (cz_r),
    .load_o     (load_w),
    .run_o      (run_w),
    .bz_o       (bz_w),
    .led_o      (led_w),
    .state_o    (state_w)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state (values visible after each clock edge)
  bit         m_valid = 1'b0;
  int         m_state = 0;
  int         m_age   = 0;
  bit         m_load  = 1'b0;
  bit         m_bz    = 1'b0;
  logic [7:0] m_led   = 8'h00;
  logic [2:0] m_acc   = 3'b000;
  logic [2:0] m_press = 3'b000;
  logic [2:0] raw_d1  = 3'b000;
  logic [2:0] raw_d2  = 3'b000;
  logic [31:0] obs_h [3];
  int          obs_n [3];

  // One clock edge of the model. Buttons: a level is accepted once the last DEB
  // synchronized samples all disagree with it; the synchronizer is a 2-edge delay.
  task automatic model_step(input bit rst, input logic [2:0] psw, input logic [3:0] rsw,
                            input bit cz);
    bit stop, rel, start, goarm, all_diff;
    logic [2:0] obs;
    if (rst) begin
      m_valid = 1'b1; m_state = 0; m_age = 0; m_load = 1'b0; m_bz = 1'b0; m_led = 8'h00;
      m_acc = 3'b000; m_press = 3'b000; raw_d1 = 3'b000; raw_d2 = 3'b000;
      for (int b = 0; b < 3; b++) begin
        obs_h[b] = 32'h0;
        obs_n[b] = 0;
      end
    end else begin
      stop  = m_press[1];
      rel   = m_press[2] & ~m_press[1];
      start = m_press[0] & ~m_press[1] & ~m_press[2];
      goarm = 1'b0;
      m_load = 1'b0;
      case (m_state)
        0: goarm = (rsw != 4'd0);
        1: if (rel) goarm = 1'b1; else if (start) m_state = 2;
        2: if (cz) begin m_state = 4; m_age = 0; end
           else if (stop) goarm = 1'b1;
           else if (start) m_state = 3;
        3: if (stop) goarm = 1'b1; else if (start) m_state = 2;
        4: if (stop) goarm = 1'b1;
           else begin
             m_age++;
             if (m_age >= TOG * PER) goarm = 1'b1;
           end
        default: m_state = 0;
      endcase
      if (goarm) begin
        m_state = (rsw == 4'd0) ? 0 : 1;
        m_load  = (rsw != 4'd0);
      end
      m_bz  = (m_state == 4) && (((m_age / PER) % 2) == 0);
      m_led = {rsw == 4'd0, 2'b00, 5'b00000};
      m_led[m_state] = 1'b1;

      obs = raw_d2;
      raw_d2 = raw_d1;
      raw_d1 = psw;
      m_press = 3'b000;
      for (int b = 0; b < 3; b++) begin
        obs_h[b] = {obs_h[b][30:0], obs[b]};
        if (obs_n[b] < DEB) obs_n[b]++;
        all_diff = (obs_n[b] >= DEB);
        for (int k = 0; k < DEB; k++) begin
          if (obs_h[b][k] == m_acc[b]) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_press[b] = ~m_acc[b];
          m_acc[b]   = ~m_acc[b];
        end
      end
    end
  endtask

  // Drive one cycle: inputs at the falling edge, check comb RUN before the rising
  // edge, then check all outputs against the model just after it.
  task automatic tick(input bit rst, input logic [3:0] psw, input logic [3:0] rsw,
                      input bit cz, output bit run_pre);
    bit exp_run;
    @(negedge clk);
    rst_r = rst; psw_r = psw; rsw_r = rsw; cz_r = cz;
    #1;
    run_pre = run_w;
    if (m_valid) begin
      exp_run = (m_state == 2) && !cz;
      n_vec++;
      if (run_w !== exp_run) begin
        n_err++;
        $display("FAIL run_comb t=%0t: run=%0b required %0b", $time, run_w, exp_run);
      end
    end
    model_step(rst, psw[2:0], rsw, cz);
    @(posedge clk);
    #1;
    exp_run = (m_state == 2) && !cz;
    n_vec++;
    if (state_w !== 3'(m_state) || load_w !== m_load || bz_w !== m_bz ||
        led_w !== m_led || run_w !== exp_run) begin
      n_err++;
      $display("FAIL model t=%0t: state=%0d load=%0b run=%0b bz=%0b led=%h, required state=%0d load=%0b run=%0b bz=%0b led=%h",
               $time, state_w, load_w, run_w, bz_w, led_w, m_state, m_load, exp_run, m_bz, m_led);
    end
  endtask

  task automatic ticks(input int n, input bit rst, input logic [3:0] psw,
                       input logic [3:0] rsw, input bit cz);
    bit rp_unused;
    for (int i = 0; i < n; i++) tick(rst, psw, rsw, cz, rp_unused);
  endtask

  task automatic check_out(input string nm, input int st, input bit ld, input bit rn,
                           input bit b, input logic [7:0] led);
    n_vec++;
    if (state_w !== 3'(st) || load_w !== ld || run_w !== rn || bz_w !== b || led_w !== led) begin
      n_err++;
      $display("FAIL %s: state=%0d load=%0b run=%0b bz=%0b led=%h, required state=%0d load=%0b run=%0b bz=%0b led=%h",
               nm, state_w, load_w, run_w, bz_w, led_w, st, ld, rn, b, led);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b required %0b", nm, act, exp);
    end
  endtask

  typedef struct {
    int         ncyc;
    bit         rst;
    logic [3:0] psw;
    logic [3:0] rsw;
    bit         cz;
    int         st;
    bit         ld;
    bit         rn;
    bit         b;
    logic [7:0] led;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int ncyc, input bit rst, input logic [3:0] psw, input logic [3:0] rsw,
                     input bit cz, input int st, input bit ld, input bit rn, input bit b,
                     input logic [7:0] led);
    vec_t v;
    v.ncyc = ncyc; v.rst = rst; v.psw = psw; v.rsw = rsw; v.cz = cz;
    v.st = st; v.ld = ld; v.rn = rn; v.b = b; v.led = led;
    tbl.push_back(v);
  endtask

  initial begin
    bit         rp;
    int         len;
    logic [3:0] p, r_rsw;
    bit         c, r;

    rst_r = 1'b1; psw_r = 4'h0; rsw_r = 4'd3; cz_r = 1'b0;

    //   ncyc rst psw   rsw cz   st ld rn bz led
    add(2,  1, 4'h0, 3, 0,  0, 0, 0, 0, 8'h00);  // reset values
    add(1,  0, 4'h0, 3, 0,  1, 1, 0, 0, 8'h02);  // arm with load
    add(1,  0, 4'h0, 3, 0,  1, 0, 0, 0, 8'h02);
    add(3,  0, 4'h1, 3, 0,  1, 0, 0, 0, 8'h02);  // 3-cycle glitch
    add(8,  0, 4'h0, 3, 0,  1, 0, 0, 0, 8'h02);
    add(6,  0, 4'h1, 3, 0,  1, 0, 0, 0, 8'h02);  // press not yet seen
    add(1,  0, 4'h1, 3, 0,  2, 0, 1, 0, 8'h04);  // 7th edge: running
    add(3,  0, 4'h1, 3, 0,  2, 0, 1, 0, 8'h04);
    add(8,  0, 4'h0, 3, 0,  2, 0, 1, 0, 8'h04);  // release ignored
    add(7,  0, 4'h1, 3, 0,  3, 0, 0, 0, 8'h08);  // pause
    add(8,  0, 4'h0, 3, 0,  3, 0, 0, 0, 8'h08);
    add(7,  0, 4'h1, 3, 0,  2, 0, 1, 0, 8'h04);  // resume
    add(8,  0, 4'h0, 3, 0,  2, 0, 1, 0, 8'h04);
    add(1,  0, 4'h0, 3, 1,  4, 0, 0, 1, 8'h10);  // zero -> alarm
    add(7,  0, 4'h0, 3, 1,  4, 0, 0, 1, 8'h10);
    add(1,  0, 4'h0, 3, 1,  4, 0, 0, 0, 8'h10);  // first toggle
    add(7,  0, 4'h0, 3, 1,  4, 0, 0, 0, 8'h10);
    add(1,  0, 4'h0, 3, 1,  4, 0, 0, 1, 8'h10);
    add(31, 0, 4'h0, 3, 1,  4, 0, 0, 0, 8'h10);  // 47 clocks in alarm
    add(1,  0, 4'h0, 3, 1,  1, 1, 0, 0, 8'h02);  // auto-stop after 48
    add(1,  0, 4'h0, 3, 0,  1, 0, 0, 0, 8'h02);

    foreach (tbl[i]) begin
      ticks(tbl[i].ncyc, tbl[i].rst, tbl[i].psw, tbl[i].rsw, tbl[i].cz);
      check_out($sformatf("table[%0d]", i), tbl[i].st, tbl[i].ld, tbl[i].rn, tbl[i].b, tbl[i].led);
    end

    // Zero detect drops RUN within the same cycle
    ticks(7, 0, 4'h1, 3, 0);
    check_out("start_run", 2, 0, 1, 0, 8'h04);
    ticks(8, 0, 4'h0, 3, 0);
    tick(0, 4'h0, 3, 1, rp);
    check1("zero_run_same_cycle", rp, 1'b0);
    check_out("zero_alarm_entry", 4, 0, 0, 1, 8'h10);

    // Stop in the middle of a high beep phase
    ticks(12, 0, 4'h0, 3, 1);
    ticks(6, 0, 4'h2, 3, 1);
    check_out("alarm_before_stop", 4, 0, 0, 1, 8'h10);
    tick(0, 4'h2, 3, 1, rp);
    check_out("alarm_stop", 1, 1, 0, 0, 8'h02);
    for (int i = 0; i < 20; i++) begin
      tick(0, 4'h0, 3, 0, rp);
      check1("alarm_silent", bz_w, 1'b0);
    end

    // All three buttons together: stop wins, nothing happens in ARMED
    for (int i = 0; i < 7; i++) begin
      tick(0, 4'h7, 3, 0, rp);
      check1("prio_no_load", load_w, 1'b0);
    end
    check_out("prio_stop_wins", 1, 0, 0, 0, 8'h02);
    ticks(8, 0, 4'h0, 3, 0);

    // Reload with RSW==0 falls back to IDLE without a load
    tick(0, 4'h0, 0, 0, rp);
    check_out("rsw_zero_led", 1, 0, 0, 0, 8'h82);
    for (int i = 0; i < 7; i++) begin
      tick(0, 4'h4, 0, 0, rp);
      check1("reload_no_load", load_w, 1'b0);
    end
    check_out("reload_to_idle", 0, 0, 0, 0, 8'h81);
    ticks(8, 0, 4'h0, 0, 0);
    check_out("idle_hold", 0, 0, 0, 0, 8'h81);
    tick(0, 4'h0, 3, 0, rp);
    check_out("rearm", 1, 1, 0, 0, 8'h02);

    // Reset with RSW==0 stays in IDLE
    ticks(2, 1, 4'h0, 0, 0);
    check_out("reset_rsw0", 0, 0, 0, 0, 8'h00);
    ticks(3, 0, 4'h0, 0, 0);
    check_out("idle_rsw0", 0, 0, 0, 0, 8'h81);
    tick(0, 4'h0, 3, 0, rp);
    check_out("arm_after_rsw", 1, 1, 0, 0, 8'h02);

    // Synchronous reset during an active beep
    ticks(7, 0, 4'h1, 3, 0);
    check_out("run_again", 2, 0, 1, 0, 8'h04);
    ticks(8, 0, 4'h0, 3, 0);
    ticks(4, 0, 4'h0, 3, 1);
    check_out("alarm_beeping", 4, 0, 0, 1, 8'h10);
    tick(1, 4'h0, 3, 1, rp);
    check_out("reset_mid_alarm", 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      tick(1, 4'h0, 3, 1, rp);
      check1("reset_no_load", load_w, 1'b0);
    end
    tick(0, 4'h0, 3, 0, rp);
    check_out("post_reset_arm", 1, 1, 0, 0, 8'h02);

    // Random stimulus against the model
    r_rsw = 4'd3;
    for (int s = 0; s < 400; s++) begin
      len = int'($urandom_range(1, 14));
      p   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) p = 4'h0;
      if ($urandom_range(0, 9) == 0) r_rsw = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 9));
      c = ($urandom_range(0, 5) == 0);
      for (int k = 0; k < len; k++) begin
        r = ($urandom_range(0, 399) == 0);
        tick(r, p, r_rsw, c, rp);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
